// File: rtl/microsequencer_pkg.sv
// Shared definitions for the microsequencer: microword field layout,
// next-state select encodings, condition select encodings and sequencer states.
package microsequencer_pkg;

    localparam int UPC_W    = 7;
    localparam int WORD_W   = 45;
    localparam int CTRL_W   = 32;

    localparam int CR_LSB   = 0;
    localparam int CR_MSB   = 6;
    localparam int NS_LSB   = 7;
    localparam int NS_MSB   = 9;
    localparam int INV_BIT  = 10;
    localparam int CSEL_LSB = 11;
    localparam int CSEL_MSB = 12;
    localparam int CTRL_LSB = 13;
    localparam int CTRL_MSB = 44;

    typedef enum logic [2:0] {
        NS_ENCODE  = 3'b000,
        NS_FETCH   = 3'b001,
        NS_INCR    = 3'b010,
        NS_CJUMP   = 3'b011,
        NS_JUMP    = 3'b100,
        NS_WAITMOC = 3'b101,
        NS_CALL    = 3'b110,
        NS_RET     = 3'b111
    } ns_e;

    typedef enum logic [1:0] {
        CSEL_PASS = 2'b00,
        CSEL_IRL  = 2'b01,
        CSEL_IRS  = 2'b10,
        CSEL_ONE  = 2'b11
    } csel_e;

    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_WAIT = 2'b01,
        ST_HALT = 2'b10
    } seq_state_e;

    // cond is packed as {IR_S, IR_L, COND_PASS}
    function automatic logic test_select(csel_e sel, logic [2:0] cond, logic inv);
        logic bit_sel;
        case (sel)
            CSEL_PASS: bit_sel = cond[0];
            CSEL_IRL:  bit_sel = cond[1];
            CSEL_IRS:  bit_sel = cond[2];
            default:   bit_sel = 1'b1;
        endcase
        return bit_sel ^ inv;
    endfunction

endpackage

// File: rtl/microsequencer_ustack.sv
// Return-address stack for microcode CALL/RET; push is ignored when full and
// pop is ignored when empty, the caller decides how to treat those cases.
module ustack
    import microsequencer_pkg::*;
#(
    parameter int STK_DEPTH = 4,
    parameter int DW        = UPC_W
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] push_data,
    output logic [DW-1:0] top,
    output logic          full,
    output logic          empty
);

    localparam int PW = $clog2(STK_DEPTH);
    localparam logic [PW:0] FULL_SP = (PW+1)'(STK_DEPTH);

    logic [PW:0]   sp;
    logic [DW-1:0] mem [STK_DEPTH];
    logic [PW-1:0] top_idx;

    assign full    = (sp == FULL_SP);
    assign empty   = (sp == '0);
    assign top_idx = PW'(sp - 1'b1);
    assign top     = empty ? '0 : mem[top_idx];

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sp <= '0;
            for (int i = 0; i < STK_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push && !full) begin
            mem[sp[PW-1:0]] <= push_data;
            sp              <= sp + 1'b1;
        end else if (pop && !empty) begin
            sp <= sp - 1'b1;
        end
    end

endmodule

// File: rtl/microsequencer.sv
// Microprogram sequencer: computes the next microstore address from the
// current microword and registers its control field into the MIR.
module microsequencer
    import microsequencer_pkg::*;
#(
    parameter int STK_DEPTH = 4,
    parameter int MOC_TMO   = 15
) (
    input  logic              clk,
    input  logic              clr,
    output logic [UPC_W-1:0]  rom_index,
    input  logic [WORD_W-1:0] rom_data,
    input  logic [UPC_W-1:0]  enc_addr,
    input  logic [2:0]        cond,
    input  logic              moc,
    output logic [CTRL_W-1:0] ctrl,
    output logic              stk_ovf,
    output logic              stk_unf,
    output logic              moc_err
);

    localparam int CNT_W = $clog2(MOC_TMO + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(MOC_TMO - 1);

    seq_state_e        state;
    logic [UPC_W-1:0]  upc;
    logic [CTRL_W-1:0] mir;
    logic [CNT_W-1:0]  wait_cnt;

    logic [UPC_W-1:0]  cr;
    ns_e               ns;
    csel_e             csel;
    logic              inv;
    logic              test;
    logic [UPC_W-1:0]  upc_inc;

    logic [UPC_W-1:0]  upc_next;
    logic              push;
    logic              pop;
    logic              wait_hold;
    logic              ovf_hit;
    logic              unf_hit;
    logic              tmo_hit;
    logic              err_hit;

    logic [UPC_W-1:0]  stk_top;
    logic              stk_full;
    logic              stk_empty;

    assign cr      = rom_data[CR_MSB:CR_LSB];
    assign ns      = ns_e'(rom_data[NS_MSB:NS_LSB]);
    assign csel    = csel_e'(rom_data[CSEL_MSB:CSEL_LSB]);
    assign inv     = rom_data[INV_BIT];
    assign test    = test_select(csel, cond, inv);
    assign upc_inc = upc + 7'd1;

    // The timeout fires on the WAIT cycle that would bring the count to MOC_TMO,
    // so moc arriving in that same cycle still wins.
    always_comb begin
        upc_next  = upc_inc;
        push      = 1'b0;
        pop       = 1'b0;
        wait_hold = 1'b0;
        ovf_hit   = 1'b0;
        unf_hit   = 1'b0;
        tmo_hit   = 1'b0;
        case (ns)
            NS_ENCODE: upc_next = enc_addr;
            NS_FETCH:  upc_next = '0;
            NS_INCR:   upc_next = upc_inc;
            NS_CJUMP:  upc_next = test ? cr : upc_inc;
            NS_JUMP:   upc_next = cr;
            NS_WAITMOC: begin
                if (!moc) begin
                    upc_next  = upc;
                    wait_hold = 1'b1;
                    tmo_hit   = (state == ST_WAIT) && (wait_cnt == TMO_LAST);
                end
            end
            NS_CALL: begin
                if (stk_full) begin
                    ovf_hit = 1'b1;
                end else begin
                    push     = 1'b1;
                    upc_next = cr;
                end
            end
            NS_RET: begin
                if (stk_empty) begin
                    unf_hit = 1'b1;
                end else begin
                    pop      = 1'b1;
                    upc_next = stk_top;
                end
            end
            default: upc_next = upc_inc;
        endcase
        if (state == ST_HALT) begin
            push    = 1'b0;
            pop     = 1'b0;
            ovf_hit = 1'b0;
            unf_hit = 1'b0;
            tmo_hit = 1'b0;
        end
    end

    assign err_hit = ovf_hit | unf_hit | tmo_hit;

    ustack #(
        .STK_DEPTH (STK_DEPTH),
        .DW        (UPC_W)
    ) u_stack (
        .clk       (clk),
        .clr       (clr),
        .push      (push),
        .pop       (pop),
        .push_data (upc_inc),
        .top       (stk_top),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    // Any error parks the sequencer at address 0 with a blank MIR until clr.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state    <= ST_RUN;
            upc      <= '0;
            mir      <= '0;
            wait_cnt <= '0;
            stk_ovf  <= 1'b0;
            stk_unf  <= 1'b0;
            moc_err  <= 1'b0;
        end else begin
            case (state)
                ST_HALT: begin
                    upc <= '0;
                    mir <= '0;
                end
                default: begin
                    if (err_hit) begin
                        state    <= ST_HALT;
                        upc      <= '0;
                        mir      <= '0;
                        wait_cnt <= '0;
                        stk_ovf  <= stk_ovf | ovf_hit;
                        stk_unf  <= stk_unf | unf_hit;
                        moc_err  <= moc_err | tmo_hit;
                    end else begin
                        upc <= upc_next;
                        mir <= rom_data[CTRL_MSB:CTRL_LSB];
                        if (wait_hold) begin
                            state    <= ST_WAIT;
                            wait_cnt <= (state == ST_WAIT) ? wait_cnt + 1'b1 : '0;
                        end else begin
                            state    <= ST_RUN;
                            wait_cnt <= '0;
                        end
                    end
                end
            endcase
        end
    end

    assign rom_index = upc;
    assign ctrl      = mir;

endmodule

// File: doc/microsequencer.md
MICROSEQUENCER -- requirements
Module: microsequencer

Interface
REQ-001 The block SHALL have parameter STK_DEPTH, default 4, meaning the number of microstack entries (power of two, 2..8).
REQ-002 The block SHALL have parameter MOC_TMO, default 15, meaning the maximum number of wait cycles for MOC before a timeout.
REQ-003 Port clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 Port clr  in  1  asynchronous, active-low reset.
REQ-005 Port rom_index  out  7  microstore address; equals the uPC register.
REQ-006 Port rom_data  in  45  microword returned combinationally for rom_index in the same cycle.
REQ-007 Port enc_addr  in  7  entry address produced by the instruction encoder for the current IR.
REQ-008 Port cond  in  3  {IR_S, IR_L, COND_PASS} test inputs.
REQ-009 Port moc  in  1  memory-operation-complete handshake.
REQ-010 Port ctrl  out  32  registered datapath control field of the executing microword (MIR).
REQ-011 Port stk_ovf, stk_unf, moc_err  out  1 each  sticky error flags.

Function
REQ-012 Microword fields SHALL be: [6:0] CR (target), [9:7] NS (next-state select), [10] INV, [12:11] CSEL, [44:13] control.
REQ-013 CSEL SHALL select the test: 00 COND_PASS, 01 IR_L, 10 IR_S, 11 constant 1; the test result is the selected bit XOR INV.
REQ-014 Each cycle, next uPC SHALL derive combinationally from rom_data and load on the clock edge; MIR SHALL load rom_data[44:13] on the same edge.
REQ-015 NS decoding: 000 ENCODE -> enc_addr; 001 FETCH -> 0; 010 INCR -> uPC+1; 011 CJUMP -> CR if test else uPC+1; 100 JUMP -> CR; 101 WAITMOC -> uPC+1 if moc else hold uPC; 110 CALL -> push uPC+1, go CR; 111 RET -> pop.
REQ-016 uPC+1 SHALL wrap modulo 128 (127 -> 0).
REQ-017 The sequencer state SHALL be one of RUN, WAIT (in a WAITMOC word with moc low), or HALT (after any error flag sets).
REQ-018 In WAIT, uPC and MIR SHALL hold the same word, so ctrl stays asserted until moc is seen.
REQ-019 The wait counter SHALL reset on entering WAIT and increment each WAIT cycle.
REQ-020 When the wait counter reaches MOC_TMO with moc still low, moc_err SHALL set and the state SHALL go to HALT.
REQ-021 moc high in the same cycle the counter reaches MOC_TMO SHALL count as success, with no error.
REQ-022 CALL with the stack full SHALL set stk_ovf, perform no push, and go to HALT.
REQ-023 RET with the stack empty SHALL set stk_unf and go to HALT.
REQ-024 In HALT, uPC SHALL be forced to 0, MIR SHALL be forced to 0, and the block SHALL remain there until clr.
REQ-025 Latency SHALL be one cycle from rom_index change to ctrl reflecting that word.

Reset
REQ-026 While clr=0, uPC, MIR, the stack pointer, all stack entries, the wait counter and all error flags SHALL be 0 and the state SHALL be RUN.
REQ-027 clr asserted mid-WAIT or mid-CALL SHALL abandon the operation immediately with no partial push.
REQ-028 On the first edge after clr release, the word at index 0 SHALL load into MIR.

Structure
REQ-029 A shared package SHALL hold the field bit positions, the NS encodings, the CSEL encodings and the state enum.
REQ-030 The stack SHALL be a sub-module named ustack, with push/pop/full/empty ports and STK_DEPTH as its parameter.

Verification
REQ-031 The bench SHALL check reset release with word0 NS=100, CR=0x05: rom_index goes 0 -> 5, and ctrl equals word0[44:13] one cycle later.
REQ-032 The bench SHALL check CJUMP at uPC 0x10, CR=0x20, CSEL=00, INV=0: COND_PASS=1 gives 0x20, COND_PASS=0 gives 0x11; with INV=1 the outcomes are reversed.
REQ-033 The bench SHALL check WAITMOC with moc low for 3 cycles then high: uPC holds for 3 cycles, advances by 1, ctrl is stable throughout, and moc_err stays 0.
REQ-034 The bench SHALL check WAITMOC with moc never asserted: moc_err sets after 15 wait cycles, then rom_index=0 and ctrl=0 until clr.
REQ-035 The bench SHALL check five nested CALLs with STK_DEPTH=4: four pushes return correctly via RET, and the fifth CALL sets stk_ovf; a RET on an empty stack sets stk_unf.
REQ-036 The bench SHALL check INCR at uPC 0x7F: the next uPC is 0x00.
